int_ctrl: RTL
=============

// Module: int_ctrl
// PURPOSE
//   Interrupt controller feeding the pc stage. Synchronises and edge-detects the
//   external buttons and latches them as pending requests. Arbitrates them
//   against syscall and issues a one-cycle start_int with int_id and source-type
//   flags to pc. Tracks handler occupancy until RTI, then holds off re-entry
//   while the pipeline drains.
// PARAMETERS
//   NUM_BTN      3   number of external button sources (1..8)
//   SYNC_STAGES  2   synchroniser flops per button (>=2)
//   DRAIN_CYCLES 3   cycles in HOLD after RTI before a new entry is allowed (>=1)
// PORTS
//   clk          in   1        single clock; all state on posedge clk
//   rst_n        in   1        asynchronous, active-low reset
//   syscall      in   1        ID-stage syscall decode, 1-cycle level
//   button       in   NUM_BTN  raw asynchronous button inputs, active high
//   int_en       in   1        global interrupt enable
//   RTI          in   1        return-from-interrupt decoded, 1-cycle level
//   start_int    out  1        registered 1-cycle entry pulse to pc
//   int_id       out  32       vector index to pc; zero-extended
//   int_syscall  out  1        high with start_int when the source is syscall
//   int_button   out  1        high with start_int when the source is a button
//   int_active   out  1        handler in progress (state SERVICE)
//   pend         out  NUM_BTN  pending button requests
// BEHAVIOUR
// - Reset: state=IDLE, every output 0, sync/prev flops 0, sys_pend=0, hold count=0.
// - Button path: SYNC_STAGES-flop synchroniser, then prev register.
//   rise[i] = sync_out[i] & ~prev[i].
//   Button high at sampling edge E0 -> pend[i]=1 after edge E0+SYNC_STAGES.
//   Because sync flops reset to 0, a button held through reset release gives exactly one request.
// - rise[i] sets pend[i]. pend[i] is cleared only when source i is taken in ENTER.
//   If set and clear occur together, set wins. Repeated rises while pending coalesce.
// - Syscall: in IDLE it is eligible in the same cycle; elsewhere it sets sys_pend.
//   sys_pend is cleared when syscall is taken.
// - Priority, highest first: syscall (live or sys_pend), then pend[0], pend[1], ...
// - int_id: syscall=0, button i=i+1. pc vector = (0x40+int_id)<<2, e.g. syscall -> 0x100, button1 -> 0x108.
// - FSM:
//   IDLE    -> ENTER when int_en & any eligible request.
//              int_id and flags are latched from the winner; the winner's pending bit is cleared.
//   ENTER   -> SERVICE unconditionally. Lasts exactly 1 cycle, so start_int=1 for that cycle only.
//              int_syscall/int_button are one-hot and valid only while start_int=1.
//   SERVICE -> HOLD on RTI. int_active=1 throughout. New requests are latched and never entered (no nesting).
//   HOLD    -> IDLE when the counter reaches DRAIN_CYCLES-1. The counter starts at 0 on entry.
//              RTI is ignored here.
// - RTI in IDLE or ENTER is ignored.
// - int_en low never drops requests; they stay pending.
// - Entry latency: 1 cycle from the eligible IDLE cycle to start_int.
// - int_id holds its last value between entries.
// - Asynchronous reset in any state returns to IDLE at once, clears all pending state and deasserts all outputs.
// TESTING
// 1 int_en=1, IDLE, syscall=1 at cycle t -> start_int=1,int_id=0,int_syscall=1 in t+1; int_active=1 from t+2.
// 2 button[1] 0->1 at edge E0, held -> pend[1]=1 after E0+2; start_int,int_id=2,int_button=1 after E0+3; pend[1]=0.
// 3 syscall and button[0] pending together -> syscall entered first; RTI -> 3 HOLD cycles -> IDLE -> start_int with int_id=1.
// 4 int_en=0, button[2] rises -> pend[2]=1, no start_int for 20 cycles; int_en=1 -> start_int next cycle with int_id=3.
// 5 In SERVICE, button[0] rises twice and syscall fires -> no start_int; after RTI+HOLD, syscall entered, then button 0 once.
// 6 rst_n low during SERVICE with pend=3'b101 -> outputs and pend 0 immediately; after release, IDLE with no spurious start_int.

Source files
------------

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises and edge-detects buttons into pending
// requests, arbitrates them against syscall and drives a one-cycle entry
// pulse with vector index to the pc stage. Tracks handler occupancy until RTI
// and then holds off re-entry while the pipeline drains.
module int_ctrl #(
   parameter int unsigned NUM_BTN      = 3,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               syscall,
   input  logic [NUM_BTN-1:0] button,
   input  logic               int_en,
   input  logic               RTI,
   output logic               start_int,
   output logic [31:0]        int_id,
   output logic               int_syscall,
   output logic               int_button,
   output logic               int_active,
   output logic [NUM_BTN-1:0] pend
);

   localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {StIdle, StEnter, StService, StHold} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [NUM_BTN-1:0]  sync_q [SYNC_STAGES];
   logic [NUM_BTN-1:0]  prev_q;
   logic [NUM_BTN-1:0]  rise;
   logic [NUM_BTN-1:0]  pend_q, pend_d;
   logic                sys_pend_q, sys_pend_d;
   logic                sc_elig, any_req, take;
   logic                win_sys;
   logic [31:0]         win_id;
   logic [NUM_BTN-1:0]  win_clr;

   // Button synchroniser chain plus previous-value register for edge detect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= button;
         for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

   // Fixed-priority arbiter: syscall first, then the lowest-numbered button.
   always_comb begin
      sc_elig = syscall | sys_pend_q;
      any_req = sc_elig | (|pend_q);
      win_sys = 1'b0;
      win_id  = '0;
      win_clr = '0;
      if (sc_elig) begin
         win_sys = 1'b1;
      end else begin
         // Descending scan so the lowest set index is the last write.
         for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
               win_id     = 32'(i + 1);
               win_clr    = '0;
               win_clr[i] = 1'b1;
            end
         end
      end
   end

   // Next-state logic for the FSM, drain counter and pending requests.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      take    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (int_en && any_req) begin
               state_d = StEnter;
               take    = 1'b1;
            end
         end
         StEnter: state_d = StService;
         StService: begin
            if (RTI) begin
               state_d = StHold;
               cnt_d   = '0;
            end
         end
         StHold: begin
            if (cnt_q == CntW'(DRAIN_CYCLES - 1)) state_d = StIdle;
            else                                  cnt_d   = cnt_q + CntW'(1);
         end
         default: state_d = StIdle;
      endcase
      // A rise in the same cycle as the clear keeps the bit set.
      pend_d     = (pend_q & ~(take ? win_clr : '0)) | rise;
      sys_pend_d = (sys_pend_q | syscall) & ~(take & win_sys);
   end

   // State registers and registered entry outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         pend_q      <= '0;
         sys_pend_q  <= 1'b0;
         start_int   <= 1'b0;
         int_id      <= '0;
         int_syscall <= 1'b0;
         int_button  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         sys_pend_q  <= sys_pend_d;
         start_int   <= take;
         int_syscall <= take & win_sys;
         int_button  <= take & ~win_sys;
         if (take) int_id <= win_id;
      end
   end

   assign int_active = (state_q == StService);
   assign pend       = pend_q;

endmodule
